// File: rtl/mapping_group_ctrl.sv
// Sequencer for a bit-sliced mapping group. For each slice it fetches one macro word
// (rbr) or two (parallel), buffers it, then accumulates. After the last slice it reads out the accumulator.
module mapping_group_ctrl #(
  parameter int SLICES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       mode_cfg_i,
  input  logic       macro_valid_i,
  output logic       macro_req_o,
  output logic       mode_o,
  output logic       buf_write_en_1_o,
  output logic       buf_write_en_2_o,
  output logic       buf_read_en_o,
  output logic [1:0] shift_count_o,
  output logic       accum_buf_write_o,
  output logic       accum_buf_read_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    REQ1 = 4'd1,
    WR1  = 4'd2,
    REQ2 = 4'd3,
    WR2  = 4'd4,
    RD   = 4'd5,
    ACC  = 4'd6,
    OUT  = 4'd7,
    DONE = 4'd8
  } state_t;

  localparam logic [1:0] LAST = 2'(SLICES - 1);

  state_t     state, state_nx;
  logic [1:0] count_nx;
  logic       mode_nx;
  logic       handshake;

  // Valid/ready rule: a macro word transfers on any rising edge where
  // macro_req_o and macro_valid_i are both high; valid is ignored otherwise.
  assign handshake = macro_req_o && macro_valid_i;
  assign state_o   = state;

  always_comb begin
    state_nx = state;
    count_nx = shift_count_o;
    mode_nx  = mode_o;
    case (state)
      IDLE: if (start_i) begin
        state_nx = REQ1;
        count_nx = 2'd0;
        mode_nx  = mode_cfg_i;
      end
      REQ1: if (handshake) state_nx = WR1;
      WR1:  state_nx = mode_o ? REQ2 : RD;
      REQ2: if (handshake) state_nx = WR2;
      WR2:  state_nx = RD;
      RD:   state_nx = ACC;
      ACC: begin
        if (shift_count_o < LAST) begin
          count_nx = shift_count_o + 2'd1;
          state_nx = REQ1;
        end else begin
          state_nx = OUT;
        end
      end
      OUT:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up
  // with the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      mode_o            <= 1'b0;
      shift_count_o     <= 2'd0;
      macro_req_o       <= 1'b0;
      buf_write_en_1_o  <= 1'b0;
      buf_write_en_2_o  <= 1'b0;
      buf_read_en_o     <= 1'b0;
      accum_buf_write_o <= 1'b0;
      accum_buf_read_o  <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      state             <= state_nx;
      mode_o            <= mode_nx;
      shift_count_o     <= count_nx;
      macro_req_o       <= (state_nx == REQ1) || (state_nx == REQ2);
      buf_write_en_1_o  <= (state_nx == WR1);
      buf_write_en_2_o  <= (state_nx == WR2);
      buf_read_en_o     <= (state_nx == RD) || (state_nx == ACC);
      accum_buf_write_o <= (state_nx == ACC);
      accum_buf_read_o  <= (state_nx == OUT);
      busy_o            <= (state_nx != IDLE);
      done_o            <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_mapping_group_ctrl.sv
// Bench for mapping_group_ctrl: an operation-level model lists the expected output
// vector for every cycle. Two DUTs (SLICES=4 and SLICES=1) share the stimulus.
module tb_mapping_group_ctrl;

  logic clk = 1'b0;
  logic rst, start, mode_cfg, valid;

  logic       req4, mode4, wr1_4, wr2_4, rd4, accw4, accr4, busy4, done4;
  logic [1:0] shift4;
  logic [3:0] st4;
  logic       req1, mode1, wr1_1, wr2_1, rd1, accw1, accr1, busy1, done1;
  logic [1:0] shift1;
  logic [3:0] st1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mapping_group_ctrl #(.SLICES(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_cfg_i(mode_cfg),
    .macro_valid_i(valid), .macro_req_o(req4), .mode_o(mode4),
    .buf_write_en_1_o(wr1_4), .buf_write_en_2_o(wr2_4), .buf_read_en_o(rd4),
    .shift_count_o(shift4), .accum_buf_write_o(accw4), .accum_buf_read_o(accr4),
    .busy_o(busy4), .done_o(done4), .state_o(st4)
  );

  mapping_group_ctrl #(.SLICES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_cfg_i(mode_cfg),
    .macro_valid_i(valid), .macro_req_o(req1), .mode_o(mode1),
    .buf_write_en_1_o(wr1_1), .buf_write_en_2_o(wr2_1), .buf_read_en_o(rd1),
    .shift_count_o(shift1), .accum_buf_write_o(accw1), .accum_buf_read_o(accr1),
    .busy_o(busy1), .done_o(done1), .state_o(st1)
  );

  // Packed view: {req, mode, wr1, wr2, rd, shift[1:0], accw, accr, busy, done}
  function automatic logic [10:0] obs(input int slices);
    if (slices == 1)
      return {req1, mode1, wr1_1, wr2_1, rd1, shift1, accw1, accr1, busy1, done1};
    return {req4, mode4, wr1_4, wr2_4, rd4, shift4, accw4, accr4, busy4, done4};
  endfunction

  function automatic logic [10:0] mk(input bit req, input bit m, input bit w1, input bit w2,
                                     input bit rd, input int sh, input bit aw, input bit ar,
                                     input bit dn);
    logic [1:0] s;
    s = 2'(sh);
    return {req, m, w1, w2, rd, s, aw, ar, 1'b1, dn};
  endfunction

  // Expected per-cycle trace of one operation, starting with the cycle after start.
  // dly < 0 picks a random valid delay for every request.
  task automatic build(input bit m, input int slices, input int dly,
                       output logic [10:0] eq[$], output bit dq[$]);
    int d;
    eq = {};
    dq = {};
    for (int s = 0; s < slices; s++) begin
      for (int w = 0; w < (m ? 2 : 1); w++) begin
        d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        for (int k = 0; k <= d; k++) begin
          eq.push_back(mk(1, m, 0, 0, 0, s, 0, 0, 0));
          dq.push_back(k == d);
        end
        eq.push_back(mk(0, m, w == 0, w == 1, 0, s, 0, 0, 0));
        dq.push_back(0);
      end
      eq.push_back(mk(0, m, 0, 0, 1, s, 0, 0, 0));
      dq.push_back(0);
      eq.push_back(mk(0, m, 0, 0, 1, s, 1, 0, 0));
      dq.push_back(0);
    end
    eq.push_back(mk(0, m, 0, 0, 0, slices - 1, 0, 1, 0));
    dq.push_back(0);
    eq.push_back(mk(0, m, 0, 0, 0, slices - 1, 0, 0, 1));
    dq.push_back(0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; valid = 1'b0; mode_cfg = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One operation. stray: random start/mode_cfg while busy.
  // abort_acc >= 0: assert reset during that slice's ACC cycle.
  task automatic run_op(input string name, input bit m, input int slices, input int dly,
                        input bit stray, input int abort_acc);
    logic [10:0] eq[$];
    bit          dq[$];
    logic [10:0] o;
    int          acc_seen, done_cyc, want;
    build(m, slices, dly, eq, dq);
    acc_seen = 0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1; mode_cfg = m; valid = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < eq.size(); i++) begin
      o = obs(slices);
      n_cmp++;
      if (o !== eq[i]) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, i + 1, o, eq[i]);
      end
      if (eq[i][0]) done_cyc = i + 1;
      if (eq[i][3] && abort_acc >= 0) begin
        if (acc_seen == abort_acc) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          o = obs(slices);
          n_cmp++;
          if (o !== 11'd0) begin
            n_err++;
            $display("FAIL %s after abort: got %b expected %b", name, o, 11'd0);
          end
          return;
        end
        acc_seen++;
      end
      valid = dq[i] ? 1'b1 : (eq[i][10] ? 1'b0 : 1'($urandom));
      if (stray) begin
        start = 1'($urandom);
        mode_cfg = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    valid = 1'b0;
    o = obs(slices);
    n_cmp++;
    if ({o[10], o[8:6], o[3:0]} !== 8'd0) begin
      n_err++;
      $display("FAIL %s idle after done: got %b expected req/strobes/busy/done all 0", name, o);
    end
    if (dly == 0) begin
      want = 2 + slices * (m ? 6 : 4);
      n_cmp++;
      if (done_cyc != want) begin
        n_err++;
        $display("FAIL %s done cycle: got %0d expected %0d", name, done_cyc, want);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs(4) !== 11'd0 || obs(1) !== 11'd0) begin
      n_err++;
      $display("FAIL reset state: got %b / %b expected 0 / 0", obs(4), obs(1));
    end
  endtask

  task automatic test_rbr();
    do_reset();
    run_op("rbr_s4", 1'b0, 4, 0, 1'b0, -1);
  endtask

  task automatic test_parallel();
    do_reset();
    run_op("par_s4", 1'b1, 4, 0, 1'b0, -1);
  endtask

  task automatic test_stall();
    do_reset();
    run_op("stall_rbr", 1'b0, 4, 3, 1'b0, -1);
    run_op("stall_par", 1'b1, 4, 3, 1'b0, -1);
  endtask

  task automatic test_busy_start();
    do_reset();
    run_op("busy_start_rbr", 1'b0, 4, 0, 1'b1, -1);
    run_op("busy_start_par", 1'b1, 4, 0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    run_op("abort_acc2", 1'b1, 4, 0, 1'b0, 2);
    run_op("after_abort", 1'b1, 4, 0, 1'b0, -1);
  endtask

  task automatic test_reset_start_priority();
    do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; mode_cfg = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(4) !== 11'd0) begin
        n_err++;
        $display("FAIL rst_start_priority cycle %0d: got %b expected %b", k, obs(4), 11'd0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_slice();
    do_reset();
    run_op("s1_rbr", 1'b0, 1, 0, 1'b0, -1);
    do_reset();
    run_op("s1_par", 1'b1, 1, 0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    bit m;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      m = 1'($urandom);
      run_op("random_s4", m, 4, -1, 1'($urandom), -1);
    end
    do_reset();
    for (int n = 0; n < 4; n++) begin
      m = 1'($urandom);
      run_op("random_s1", m, 1, -1, 1'($urandom), -1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode_cfg = 1'b0; valid = 1'b0;
    test_reset();
    test_rbr();
    test_parallel();
    test_stall();
    test_busy_start();
    test_reset_mid_op();
    test_reset_start_priority();
    test_single_slice();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mapping_group_ctrl.md
MAPPING_GROUP_CTRL -- requirements
Module: mapping_group_ctrl

Interface
REQ-001 SHALL have parameter SLICES, default 4, meaning the number of bit-slices per operation; legal values 1..4.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk_i  input  1  rising-edge clock; rst_i  input  1  synchronous active-high reset.
REQ-003 SHALL have start_i  input  1  one-cycle operation start request.
REQ-004 SHALL have mode_cfg_i  input  1  requested mode: 0 = row-by-row (rbr), 1 = parallel.
REQ-005 SHALL have macro_valid_i  input  1  macro output data is valid and stable while macro_req_o is high.
REQ-006 SHALL have macro_req_o  output  1  request for the next macro output word.
REQ-007 SHALL have mode_o  output  1  latched mode, driven to the mapping group mode input.
REQ-008 SHALL have buf_write_en_1_o and buf_write_en_2_o  output  1 each  write strobes for output buffers 1 and 2.
REQ-009 SHALL have buf_read_en_o  output  1  output buffer read enable.
REQ-010 SHALL have shift_count_o  output  2  current slice index, which sets the shift amount.
REQ-011 SHALL have accum_buf_write_o  output  1  accumulate strobe.
REQ-012 SHALL have accum_buf_read_o  output  1  read-and-clear strobe for the accumulator.
REQ-013 SHALL have busy_o  output  1  operation in progress.
REQ-014 SHALL have done_o  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement the states IDLE, REQ1, WR1, REQ2, WR2, RD, ACC, OUT and DONE, with all outputs registered.
REQ-016 SHALL leave IDLE for REQ1 on start_i, latching mode_cfg_i into mode_o and clearing the slice counter to 0.
REQ-017 SHALL, in REQ1 and REQ2, assert macro_req_o and wait; the handshake completes in any cycle where macro_req_o and macro_valid_i are both high, and the state then moves to WR1 or WR2 respectively.
REQ-018 SHALL assert buf_write_en_1_o for exactly one cycle in WR1, then go to REQ2 if mode_o = 1 or to RD if mode_o = 0.
REQ-019 SHALL assert buf_write_en_2_o for exactly one cycle in WR2, then go to RD; the macro holds its data through the WR cycle.
REQ-020 SHALL assert buf_read_en_o in both RD and ACC, and additionally assert accum_buf_write_o in ACC only.
REQ-021 SHALL drive shift_count_o equal to the slice counter and hold it stable from WR1 through ACC of that slice.
REQ-022 SHALL, after ACC, increment the slice counter and return to REQ1 if the counter is below SLICES-1; otherwise it SHALL go to OUT.
REQ-023 SHALL assert accum_buf_read_o for one cycle in OUT, assert done_o for one cycle in DONE, then return to IDLE.
REQ-024 SHALL drive busy_o = 1 in every state except IDLE.
REQ-025 SHALL ignore start_i while busy_o = 1, with no queuing.
REQ-026 SHALL ignore macro_valid_i outside REQ1 and REQ2.
REQ-027 SHALL keep mode_o constant for the whole operation; a change on mode_cfg_i while busy SHALL have no effect.
REQ-028 SHALL never assert two of buf_write_en_1_o, buf_write_en_2_o and accum_buf_read_o in the same cycle.
REQ-029 SHALL, with macro_valid_i held at 1, use 4 cycles per rbr slice and 6 cycles per parallel slice.
REQ-030 SHALL, with start_i sampled at cycle 0, produce done_o at cycle 2 + SLICES*4 (rbr) or cycle 2 + SLICES*6 (parallel).

Reset
REQ-031 SHALL, when rst_i is high at a clock edge, enter IDLE, clear the slice counter, and drive every output to 0 (mode_o = 0, shift_count_o = 0) on the next cycle.
REQ-032 SHALL, on reset mid-operation, abort without asserting done_o or accum_buf_read_o; the accumulator contents are then undefined until the next OUT.
REQ-033 SHALL, when rst_i and start_i are high together, give reset priority and not start an operation.

Verification
REQ-034 SHALL cover: rbr mode, SLICES=4, macro_valid_i=1, start at cycle 0 -> buf_write_en_1_o at cycles 2/6/10/14; shift_count_o 0,1,2,3; accum_buf_read_o at cycle 17; done_o at cycle 18.
REQ-035 SHALL cover: parallel mode, SLICES=4, macro_valid_i=1 -> per slice buf_write_en_1_o then buf_write_en_2_o two cycles apart; accum_buf_write_o at cycles 6/12/18/24; done_o at cycle 26.
REQ-036 SHALL cover: macro_valid_i delayed 3 cycles on each request -> macro_req_o stays high for 4 cycles; no write strobe until the handshake; shift_count_o unchanged during the stall.
REQ-037 SHALL cover: start_i pulsed while busy, with mode_cfg_i toggled -> ignored; mode_o and the cycle count match the original run.
REQ-038 SHALL cover: rst_i asserted during ACC of slice 2 -> next cycle all outputs 0 and busy_o = 0; a subsequent start performs a full, correct sequence.
REQ-039 SHALL cover: SLICES=1, rbr mode -> one slice with shift_count_o = 0; accum_buf_read_o at cycle 5; done_o at cycle 6.
